// File: rtl/pipeline_control_unit_if.sv
// Signals between the pipeline hazard/decode logic and the pipeline control unit.
// The control unit connects through the slave modport and the pipeline side through master.
interface pipeline_control_unit_if #(
  parameter int CNT_W = 16
);
  logic             stall_req;
  logic [1:0]       forward_rs1_id;
  logic [1:0]       forward_rs2_id;
  logic [1:0]       forward_store_id;
  logic             branch_taken_ex;
  logic             muldiv_start_ex;
  logic             muldiv_done;

  logic             pc_write_en;
  logic             if_id_write_en;
  logic             if_id_flush;
  logic             id_ex_write_en;
  logic             id_ex_bubble;
  logic             ex_ma_bubble;
  logic [1:0]       forward_rs1_ex;
  logic [1:0]       forward_rs2_ex;
  logic [1:0]       forward_store_ex;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles;

  modport slave (
    input  stall_req, forward_rs1_id, forward_rs2_id, forward_store_id,
           branch_taken_ex, muldiv_start_ex, muldiv_done,
    output pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
           id_ex_bubble, ex_ma_bubble, forward_rs1_ex, forward_rs2_ex,
           forward_store_ex, busy, stall_cycles
  );

  modport master (
    output stall_req, forward_rs1_id, forward_rs2_id, forward_store_id,
           branch_taken_ex, muldiv_start_ex, muldiv_done,
    input  pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
           id_ex_bubble, ex_ma_bubble, forward_rs1_ex, forward_rs2_ex,
           forward_store_ex, busy, stall_cycles
  );
endinterface

// File: rtl/pipeline_control_unit.sv
// Pipeline stall/flush sequencing for load-use, taken branches and multi-cycle RV32M ops.
// state  | meaning
// RUN    | normal issue; branch > muldiv start > load-use stall
// MDBUSY | EX held on a multi-cycle op until done or hold limit
module pipeline_control_unit #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pipeline_control_unit_if.slave  bus
);

  typedef enum logic [0:0] {RUN = 1'b0, MDBUSY = 1'b1} state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MD_LATENCY - 1);

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [1:0]       fwd_rs1_q, fwd_rs1_d;
  logic [1:0]       fwd_rs2_q, fwd_rs2_d;
  logic [1:0]       fwd_st_q, fwd_st_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic pc_we, if_id_we, if_id_fl, id_ex_we, id_ex_bub, ex_ma_bub;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pc_we     = 1'b1;
    if_id_we  = 1'b1;
    if_id_fl  = 1'b0;
    id_ex_we  = 1'b1;
    id_ex_bub = 1'b0;
    ex_ma_bub = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.branch_taken_ex) begin
          if_id_fl  = 1'b1;
          id_ex_bub = 1'b1;
        end else if (bus.muldiv_start_ex) begin
          // a result already available in the start cycle needs no hold
          if (!bus.muldiv_done) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_ma_bub = 1'b1;
            hold_d    = 8'd1;
            state_d   = MDBUSY;
          end
        end else if (bus.stall_req) begin
          pc_we     = 1'b0;
          if_id_we  = 1'b0;
          id_ex_bub = 1'b1;
        end
      end
      MDBUSY: begin
        if (bus.muldiv_done || hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          pc_we     = 1'b0;
          if_id_we  = 1'b0;
          id_ex_we  = 1'b0;
          ex_ma_bub = 1'b1;
          hold_d    = hold_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    fwd_rs1_d = fwd_rs1_q;
    fwd_rs2_d = fwd_rs2_q;
    fwd_st_d  = fwd_st_q;
    if (id_ex_we) begin
      fwd_rs1_d = id_ex_bub ? 2'b00 : bus.forward_rs1_id;
      fwd_rs2_d = id_ex_bub ? 2'b00 : bus.forward_rs2_id;
      fwd_st_d  = id_ex_bub ? 2'b00 : bus.forward_store_id;
    end
    stall_cnt_d = stall_cnt_q;
    if (!pc_we && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= RUN;
      hold_q      <= 8'd0;
      fwd_rs1_q   <= 2'b00;
      fwd_rs2_q   <= 2'b00;
      fwd_st_q    <= 2'b00;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      fwd_rs1_q   <= fwd_rs1_d;
      fwd_rs2_q   <= fwd_rs2_d;
      fwd_st_q    <= fwd_st_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_write_en      = pc_we;
  assign bus.if_id_write_en   = if_id_we;
  assign bus.if_id_flush      = if_id_fl;
  assign bus.id_ex_write_en   = id_ex_we;
  assign bus.id_ex_bubble     = id_ex_bub;
  assign bus.ex_ma_bubble     = ex_ma_bub;
  assign bus.forward_rs1_ex   = fwd_rs1_q;
  assign bus.forward_rs2_ex   = fwd_rs2_q;
  assign bus.forward_store_ex = fwd_st_q;
  assign bus.busy             = (state_q == MDBUSY);
  assign bus.stall_cycles     = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench: a vector table of single RUN-state cycles plus hand-written
// multi-cycle sequences (muldiv early done, timeout, reset mid-op, saturation).
module tb_pipeline_control_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_control_unit_if #(.CNT_W(16)) b0 ();
  pipeline_control_unit_if #(.CNT_W(4))  b1 ();

  pipeline_control_unit #(.MD_LATENCY(32), .CNT_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(b0)
  );
  pipeline_control_unit #(.MD_LATENCY(2), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1)
  );

  typedef struct {
    logic       stall, br, mds, mdd;
    logic [1:0] r1, r2, st;
    logic [5:0] ctl;   // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_ma_bubble}
    logic [5:0] fwd;   // {rs1_ex, rs2_ex, store_ex} after the edge
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_sc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ctl0();
    return {b0.pc_write_en, b0.if_id_write_en, b0.if_id_flush,
            b0.id_ex_write_en, b0.id_ex_bubble, b0.ex_ma_bubble};
  endfunction

  function automatic logic [5:0] ctl1();
    return {b1.pc_write_en, b1.if_id_write_en, b1.if_id_flush,
            b1.id_ex_write_en, b1.id_ex_bubble, b1.ex_ma_bubble};
  endfunction

  function automatic logic [5:0] fwd0();
    return {b0.forward_rs1_ex, b0.forward_rs2_ex, b0.forward_store_ex};
  endfunction

  task automatic drive0(input logic stall, input logic br, input logic mds, input logic mdd,
                        input logic [1:0] r1, input logic [1:0] r2, input logic [1:0] st);
    b0.stall_req        = stall;
    b0.branch_taken_ex  = br;
    b0.muldiv_start_ex  = mds;
    b0.muldiv_done      = mdd;
    b0.forward_rs1_id   = r1;
    b0.forward_rs2_id   = r2;
    b0.forward_store_id = st;
  endtask

  localparam logic [5:0] CTL_NORM  = 6'b110100;
  localparam logic [5:0] CTL_HOLD  = 6'b000001;
  localparam logic [5:0] CTL_STALL = 6'b000110;
  localparam logic [5:0] CTL_BR    = 6'b111110;

  vec_t vecs[11];

  initial begin
    int busy_n;
    int pc_low;
    int cyc;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b11, CTL_NORM,  6'b011011};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, CTL_STALL, 6'b000000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, CTL_NORM,  6'b100110};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 2'b11, CTL_BR,    6'b000000};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 2'b01, CTL_BR,    6'b000000};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 2'b01, CTL_NORM,  6'b111001};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 2'b01, CTL_NORM,  6'b010101};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b10, CTL_STALL, 6'b000000};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 2'b10, CTL_STALL, 6'b000000};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, CTL_NORM,  6'b001101};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b10, CTL_NORM,  6'b010010};

    drive0(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 2'b11);
    b1.stall_req = 1'b0; b1.branch_taken_ex = 1'b0; b1.muldiv_start_ex = 1'b0;
    b1.muldiv_done = 1'b0; b1.forward_rs1_id = 2'b00; b1.forward_rs2_id = 2'b00;
    b1.forward_store_id = 2'b00;

    // reset state, held and then released with idle requests
    reset_n = 1'b0;
    tick(); tick();
    chk("rst_ctl", ctl0(), CTL_NORM);
    chk("rst_busy", b0.busy, 0);
    chk("rst_fwd", fwd0(), 0);
    chk("rst_sc", b0.stall_cycles, 0);
    chk("rst_sc1", b1.stall_cycles, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ctl", ctl0(), CTL_NORM);
    chk("post_rst_busy", b0.busy, 0);

    // single-cycle RUN vectors
    for (int i = 0; i < 11; i++) begin
      drive0(vecs[i].stall, vecs[i].br, vecs[i].mds, vecs[i].mdd,
             vecs[i].r1, vecs[i].r2, vecs[i].st);
      #1;
      chk($sformatf("vec%0d_ctl", i), ctl0(), vecs[i].ctl);
      if (!vecs[i].ctl[5]) exp_sc++;
      tick();
      chk($sformatf("vec%0d_fwd", i), fwd0(), vecs[i].fwd);
      chk($sformatf("vec%0d_busy", i), b0.busy, 0);
      chk($sformatf("vec%0d_sc", i), b0.stall_cycles, exp_sc);
    end

    // muldiv with done on the 5th cycle after start; branch/stall ignored while busy
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b11);
    tick();
    chk("md_pre_fwd", fwd0(), 6'b011011);
    drive0(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b01, 2'b00);
    #1;
    chk("md_start_ctl", ctl0(), CTL_HOLD);
    tick();
    exp_sc++;
    chk("md_start_busy", b0.busy, 1);
    for (int k = 1; k <= 4; k++) begin
      drive0(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'(k), 2'b01);
      #1;
      chk($sformatf("md_busy%0d_ctl", k), ctl0(), CTL_HOLD);
      tick();
      exp_sc++;
      chk($sformatf("md_busy%0d_busy", k), b0.busy, 1);
      chk($sformatf("md_busy%0d_rs2", k), b0.forward_rs2_ex, 2'b10);
    end
    drive0(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b11, 2'b01);
    #1;
    chk("md_done_ctl", ctl0(), CTL_NORM);
    chk("md_done_busy", b0.busy, 1);
    tick();
    chk("md_exit_busy", b0.busy, 0);
    chk("md_exit_fwd", fwd0(), 6'b101101);
    chk("md_exit_sc", b0.stall_cycles, exp_sc);

    // muldiv timeout with done never asserted
    drive0(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    #1;
    pc_low = b0.pc_write_en ? 0 : 1;
    tick();
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    busy_n = 0;
    cyc = 0;
    while (b0.busy && cyc < 100) begin
      busy_n++;
      if (!b0.pc_write_en) pc_low++;
      tick();
      cyc++;
    end
    if (cyc >= 100) begin
      checks++; errors++;
      $display("FAIL to_timeout busy still high after %0d cycles", cyc);
    end
    exp_sc += 31;
    chk("to_busy_cycles", busy_n, 31);
    chk("to_pc_low_cycles", pc_low, 31);
    chk("to_sc", b0.stall_cycles, exp_sc);
    chk("to_after_ctl", ctl0(), CTL_NORM);

    // reset asserted on the 10th busy cycle
    drive0(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b11, 2'b01);
    tick();
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b11, 2'b01);
    for (int k = 0; k < 9; k++) tick();
    chk("rmo_busy_before", b0.busy, 1);
    reset_n = 1'b0;
    tick();
    chk("rmo_busy", b0.busy, 0);
    chk("rmo_sc", b0.stall_cycles, 0);
    chk("rmo_fwd", fwd0(), 0);
    chk("rmo_ctl", ctl0(), CTL_NORM);
    reset_n = 1'b1;
    tick();
    chk("rmo_rel_ctl", ctl0(), CTL_NORM);
    chk("rmo_rel_busy", b0.busy, 0);

    // 4-bit counter saturation, then MD_LATENCY=2 minimum hold
    b1.stall_req = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("sat_sc3", b1.stall_cycles, 3);
    for (int k = 0; k < 17; k++) tick();
    chk("sat_sc20", b1.stall_cycles, 15);
    b1.stall_req = 1'b0;
    b1.muldiv_start_ex = 1'b1;
    #1;
    chk("lat2_start_ctl", ctl1(), CTL_HOLD);
    tick();
    b1.muldiv_start_ex = 1'b0;
    #1;
    chk("lat2_busy", b1.busy, 1);
    chk("lat2_exit_ctl", ctl1(), CTL_NORM);
    tick();
    chk("lat2_done_busy", b1.busy, 0);
    chk("lat2_sc", b1.stall_cycles, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
